// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
package nibble_serial_adder_pkg;

  // Width of one adder slice pass.
  localparam int NIB_W = 4;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit adder slice with generate/propagate prefix carries.
module add4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  logic [NIB_W-1:0] w_g;
  logic [NIB_W-1:0] w_p;
  logic [NIB_W:0]   w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Every carry is a flat function of g/p and cin, so no ripple through the slice.
  always_comb begin
    w_c[0] = cin;
    w_c[1] = w_g[0] | (w_p[0] & cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & cin);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);
  end

  assign s    = w_p ^ w_c[NIB_W-1:0];
  assign cout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder/subtractor producing one nibble per clock through a single
// 4-bit slice; the carry register is the only path between nibbles.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Input side: in_ready is high only in IDLE; operands are sampled on the
// accepting edge and ignored afterwards. Output side: out_valid is high only in
// DONE; sum/cout/ovf stay stable until the edge where out_ready is also high.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;
  logic [NIB_W-1:0] w_x;
  logic [NIB_W-1:0] w_y;
  logic [NIB_W-1:0] w_s;
  logic             w_c;
  logic             w_last;
  logic             w_accept;

  // Nibble mux: pick the operand nibbles addressed by the pass index.
  assign w_x      = r_opa[NIB_W*r_idx +: NIB_W];
  assign w_y      = r_opb[NIB_W*r_idx +: NIB_W];
  assign w_last   = (r_idx == LAST_IDX);
  assign w_accept = (r_state == ST_IDLE) && in_valid;

  add4_slice u_slice (
    .x    (w_x),
    .y    (w_y),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Next-state logic: accept in IDLE, run NIB passes, hold result until taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Datapath: latch operands on accept, then write one result nibble per pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B here and inject the +1 as carry-in.
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= sub;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum[NIB_W*r_idx +: NIB_W] <= w_s;
      r_carry <= w_c;
      r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
      if (w_last) begin
        r_cout <= w_c;
        // Carry into the MSB is recovered from that bit's sum and operands.
        r_ovf  <= w_s[NIB_W-1] ^ w_x[NIB_W-1] ^ w_y[NIB_W-1] ^ w_c;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed cases, handshake scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries are {cout, ovf, sum}.
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    if (s) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    c = full[W];
    // Signed overflow from operand/result signs.
    if (s) o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else   o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {c, o, r};
  endfunction

  // ---------------- driver tasks ----------------
  // Present operands, check in_ready, return #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                          input string name);
    a = ta; b = tb; sub = ts; in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready before accept: got %b expected 1", name, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for out_valid, checking latency, in_ready and the result.
  task automatic wait_done(input string name);
    int lat = 0;
    bit rdy_bad = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) rdy_bad = 1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    checks++;
    if (lat != NIB) begin
      errors++;
      $display("FAIL %s latency: got %0d edges expected %0d", name, lat, NIB);
    end
    checks++;
    if (rdy_bad) begin
      errors++;
      $display("FAIL %s in_ready during RUN: got 1 expected 0", name);
    end
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty: got result with no expectation", name);
      return;
    end
    last_exp = exp_q.pop_front();
    checks++;
    if (sum !== last_exp[W-1:0]) begin
      errors++;
      $display("FAIL %s sum: got %h expected %h", name, sum, last_exp[W-1:0]);
    end
    checks++;
    if (cout !== last_exp[W+1]) begin
      errors++;
      $display("FAIL %s cout: got %b expected %b", name, cout, last_exp[W+1]);
    end
    checks++;
    if (ovf !== last_exp[W]) begin
      errors++;
      $display("FAIL %s ovf: got %b expected %b", name, ovf, last_exp[W]);
    end
  endtask

  // Optionally stall, then complete the output handshake.
  task automatic handshake(input string name, input int delay);
    bit held = 1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) held = 0;
    end
    checks++;
    if (!held) begin
      errors++;
      $display("FAIL %s out_valid dropped while stalled: got 0 expected 1", name);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after handshake: got out_valid=%b in_ready=%b expected 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s handshake outputs: got in_ready=%b out_valid=%b expected 1/0",
               name, in_ready, out_valid);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s result outputs: got sum=%h cout=%b ovf=%b expected 0000/0/0",
               name, sum, cout, ovf);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_cleared("reset_initial");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    // Reset asserted mid-cycle in RUN after two nibbles have been written.
    start_op(16'h1234, 16'h4321, 1'b0, "reset_mid");
    @(posedge clk); @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check_cleared("reset_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[6] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    logic [W-1:0] tb[6] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1234};
    logic         ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [W+1:0] te[6] = '{{2'b00, 16'h5555}, {2'b10, 16'h0000}, {2'b01, 16'h8000},
                            {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}, {2'b10, 16'h0000}};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(te[i]);
      start_op(ta[i], tb[i], ts[i], $sformatf("directed%0d", i));
      wait_done($sformatf("directed%0d", i));
      handshake($sformatf("directed%0d", i), 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta[3];
    logic [W-1:0] tb[3];
    logic         ts[3];
    for (int i = 0; i < 3; i++) begin
      ta[i] = W'($urandom); tb[i] = W'($urandom); ts[i] = 1'($urandom_range(0, 1));
    end
    a = ta[0]; b = tb[0]; sub = ts[0]; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(ta[i], tb[i], ts[i]));
      @(posedge clk); #1;
      if (i < 2) begin
        a = ta[i+1]; b = tb[i+1]; sub = ts[i+1];
      end else begin
        in_valid = 1'b0;
      end
      wait_done($sformatf("b2b%0d", i));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b%0d idle after handshake: got in_ready=%b out_valid=%b expected 1/0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    logic [W-1:0] na = 16'h00F0;
    logic [W-1:0] nb = 16'h0F0F;
    exp_q.push_back(model(16'hABCD, 16'h1357, 1'b1));
    start_op(16'hABCD, 16'h1357, 1'b1, "bp");
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (sum !== last_exp[W-1:0] || cout !== last_exp[W+1] || ovf !== last_exp[W] ||
          in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp hold: got sum=%h cout=%b ovf=%b in_ready=%b expected %h/%b/%b/0",
               sum, cout, ovf, in_ready, last_exp[W-1:0], last_exp[W+1], last_exp[W]);
    end
    // New operands waiting while the result handshake happens.
    a = na; b = nb; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp idle after handshake: got in_ready=%b out_valid=%b expected 1/0",
               in_ready, out_valid);
    end
    exp_q.push_back(model(na, nb, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp new accept: got in_ready=%b expected 0", in_ready);
    end
    wait_done("bp_next");
    handshake("bp_next", 0);
  endtask

  task automatic test_abort();
    bit seen = 0;
    start_op(16'hFFFF, 16'h0001, 1'b0, "abort");
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_cleared("abort");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid === 1'b1) seen = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort out_valid: got 1 expected 0");
    end
    exp_q.push_back({2'b00, 16'h0003});
    start_op(16'h0001, 16'h0002, 1'b0, "abort_after");
    wait_done("abort_after");
    handshake("abort_after", 1);
  endtask

  task automatic test_random();
    logic [W-1:0] corner[4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    logic         ts;
    for (int i = 0; i < 30; i++) begin
      ta = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      tb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      ts = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ta, tb, ts));
      start_op(ta, tb, ts, $sformatf("rand%0d", i));
      wait_done($sformatf("rand%0d", i));
      handshake($sformatf("rand%0d", i), $urandom_range(0, 3));
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder/subtractor that produces 4 sum bits per clock through one 4-bit combinational adder slice, carrying between nibbles in a register.
- Sits between the operand-issue logic and the result writeback.
- Trades latency for area against a full-width parallel adder.
- valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4 (derived, localparam), number of slice passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A−B (A + ~B + 1)
- out_valid  output  1  result valid
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- State machine: IDLE, RUN, DONE.
- Reset, async, takes effect immediately:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - sum = 0; cout = 0; ovf = 0.
  - Nibble index = 0; carry register = 0; operand registers = 0.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1:
    - Latch a into opA.
    - Latch b into opB, or ~b if sub = 1.
    - Carry register = sub.
    - Index = 0; go to RUN.
- RUN:
  - in_ready = 0; in_valid is ignored.
  - Each cycle the slice adds nibble[idx] of opA and opB plus the carry register.
  - On the edge:
    - Slice sum is written into sum[4*idx+3 : 4*idx].
    - Carry register takes the slice carry-out.
    - idx increments.
  - On the pass with idx = NIB−1, the same edge also:
    - Sets cout = slice carry-out.
    - Sets ovf = (carry into bit WIDTH−1) XOR (slice carry-out), where carry into bit WIDTH−1 = s[3] ^ opA_msb ^ opB_msb of that slice.
    - Goes to DONE.
- Latency: out_valid rises exactly NIB clock edges after the accepting edge (4 for WIDTH = 16).
- DONE:
  - out_valid = 1.
  - sum, cout and ovf held stable until out_valid && out_ready.
  - On that edge: out_valid → 0, go to IDLE.
  - in_ready stays 0 in DONE: no overlap.
  - Throughput is one operation per NIB + 2 cycles minimum.
- sum may be read only while out_valid = 1. Sum nibbles update progressively during RUN; this is permitted.
- Carry chain rules:
  - The carry register is the only inter-nibble path.
  - Nibble 0 carry-in equals sub.
  - There is no other carry input.
- Wrap-around: the result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.
- Reset asserted in RUN or DONE aborts the operation. No out_valid is issued for it, and the block returns to IDLE on reset release.
- out_ready asserted outside DONE has no effect.
- in_valid held high through an entire operation is accepted again only on the first IDLE cycle after the result handshake.

Decomposition:
- Shared package holds:
  - the state encoding constants IDLE/RUN/DONE (2-bit);
  - the nibble width constant 4.
- One natural sub-module: add4_slice. It is a combinational 4-bit adder with inputs x[3:0], y[3:0], cin and outputs s[3:0], cout, and uses prefix (generate/propagate) carry logic.
- nibble_serial_adder instantiates exactly one add4_slice. The nibble mux/demux, FSM and registers are in the top.

Test Plan:
- Reset: assert rst mid-cycle → immediately in_ready = 1, out_valid = 0, sum = 0x0000, cout = 0, ovf = 0.
- ADD, sub = 0: 0x1234 + 0x4321 → sum 0x5555, cout 0, ovf 0. out_valid high exactly 4 edges after the accept edge, and in_ready = 0 during RUN.
- Full ripple: 0xFFFF + 0x0001, sub = 0 → sum 0x0000, cout 1, ovf 0. Also 0x7FFF + 0x0001 → sum 0x8000, cout 0, ovf 1.
- SUB:
  - 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0.
  - 0x8000 − 0x0001 → 0x7FFF, cout 1, ovf 1.
  - 0x1234 − 0x1234 → 0x0000, cout 1, ovf 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while toggling in_valid and a/b → sum/cout/ovf unchanged and in_ready stays 0. Then out_ready = 1 → one handshake, IDLE next cycle; a new operation is accepted only then.
- Abort: assert rst after the 2nd RUN edge of 0xFFFF + 0x0001 → out_valid never asserts and outputs clear. After release, 0x0001 + 0x0002 → sum 0x0003, with no stale carry.
